microcode_sequencer: RTL and testbench

Parametrised microcoded control sequencer, the successor to the fixed 8-bit/3-step control unit. It runs a step counter over an external control-store ROM and latches the instruction during the fetch step. It adds variable-length micro-programs via an end-of-instruction bit, a sticky halt state with resume, and an optional stall input. It sits between the instruction/data bus, the control-store ROM, and every datapath control input (ALU, register file, RAM, PC).

---
 rtl/microcode_sequencer.sv | 121 ++++++++++++
 tb/tb_microcode_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// Microcoded control sequencer: step counter over an external control-store ROM.
// Optional stall input enabled by defining MICROSEQ_STALL_EN.
module microcode_sequencer #(
    parameter int INSTR_W = 8,
    parameter int STEP_W  = 3,
    parameter int FLAG_W  = 2,
    parameter int CTRL_W  = 16,
    parameter int IMM_W   = 8,
    parameter int IMM_LSB = 3,
    parameter int IMM_FW  = 3
) (
    input  logic                              i_clk,
    input  logic                              i_nReset,
    input  logic [FLAG_W-1:0]                 i_flags,
    input  logic [INSTR_W-1:0]                i_instruction,
    input  logic                              i_continue,
`ifdef MICROSEQ_STALL_EN
    input  logic                              i_stall,
`endif
    output logic [FLAG_W+INSTR_W+STEP_W-1:0]  o_csAddress,
    input  logic [CTRL_W-1:0]                 i_csData,
    output logic [CTRL_W-3:0]                 o_ctrl,
    output logic [IMM_W-1:0]                  o_immediate,
    output logic                              o_fetch,
    output logic                              o_pcNOe,
    output logic                              o_hlt,
    output logic [STEP_W-1:0]                 o_step
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_TWO = STEP_W'(2);

    state_t               state_q, state_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;

    logic                 u_end;
    logic                 n_imm_out;
    logic                 hold;
    logic                 halt_hit;
    logic                 issue;
    logic [IMM_W-1:0]     imm_ext;

    assign u_end     = i_csData[CTRL_W-1];
    assign n_imm_out = i_csData[0];

`ifdef MICROSEQ_STALL_EN
    assign hold = i_stall;
`else
    assign hold = 1'b0;
`endif

    // The HALT opcode is recognised at its first execute step; that word is suppressed.
    assign halt_hit = (state_q == ST_RUN) && (step_q == STEP_TWO) && (&instr_q);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        instr_d = instr_q;
        case (state_q)
            ST_RUN: begin
                if (!hold) begin
                    if (step_q == STEP_ONE) begin
                        instr_d = i_instruction;
                    end
                    if (halt_hit) begin
                        state_d = ST_HALT;
                    end else if ((step_q > STEP_ONE) && u_end) begin
                        step_d = '0;
                    end else begin
                        step_d = step_q + STEP_ONE;
                    end
                end
            end
            ST_HALT: begin
                // Resume wins over stall while halted.
                if (i_continue) begin
                    state_d = ST_RUN;
                    step_d  = '0;
                    instr_d = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nReset) begin
            state_q <= ST_RUN;
            step_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        imm_ext             = '0;
        imm_ext[IMM_FW-1:0] = instr_q[IMM_LSB +: IMM_FW];
    end

    assign issue = i_nReset && (state_q == ST_RUN) && !halt_hit;

    assign o_csAddress = {i_flags, instr_q, step_q};
    assign o_ctrl      = issue ? i_csData[CTRL_W-2:1] : '0;
    assign o_immediate = (issue && !n_imm_out) ? imm_ext : '0;
    assign o_fetch     = (step_q == STEP_ONE);
    assign o_pcNOe     = (step_q != '0);
    assign o_hlt       = (state_q == ST_HALT);
    assign o_step      = step_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer; the bench also acts as the ROM.
// Stall scenarios are exercised only when MICROSEQ_STALL_EN is defined.
module tb_microcode_sequencer;

    localparam int OBS_W = 13 + 14 + 8 + 3 + 3;

    typedef struct {
        logic [2:0] s;
        logic [7:0] ir;
        logic       iss;
        logic       h;
        logic [7:0] d;
        logic       c;
        logic       r;
        logic       st;
        logic [1:0] f;
    } item_t;

    logic        clk;
    logic        nrst;
    logic [1:0]  flags;
    logic [7:0]  din;
    logic        cont;
    logic        stall;
    logic [12:0] cs_address;
    logic [15:0] cs_data;
    logic [13:0] ctrl;
    logic [7:0]  imm;
    logic        fetch;
    logic        pc_noe;
    logic        hlt;
    logic [2:0]  step;

    logic        force_ones;
    logic        nimm;
    logic [7:0]  uend_mask;

    item_t       q[$];
    int          pass_cnt;
    int          total_cnt;

    microcode_sequencer dut (
        .i_clk         (clk),
        .i_nReset      (nrst),
        .i_flags       (flags),
        .i_instruction (din),
        .i_continue    (cont),
`ifdef MICROSEQ_STALL_EN
        .i_stall       (stall),
`endif
        .o_csAddress   (cs_address),
        .i_csData      (cs_data),
        .o_ctrl        (ctrl),
        .o_immediate   (imm),
        .o_fetch       (fetch),
        .o_pcNOe       (pc_noe),
        .o_hlt         (hlt),
        .o_step        (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [12:0] a);
        logic [15:0] w;
        if (force_ones) return 16'hFFFF;
        w[15]   = uend_mask[a[2:0]];
        w[14:1] = 14'({1'b0, a} * 14'd37) ^ 14'h1A5C;
        w[0]    = nimm;
        return w;
    endfunction

    always_comb cs_data = rom(cs_address);

    function automatic logic [OBS_W-1:0] obs();
        return {cs_address, ctrl, imm, step, fetch, pc_noe, hlt};
    endfunction

    function automatic logic [OBS_W-1:0] expv(input item_t it);
        logic [12:0] a;
        logic [15:0] w;
        logic [13:0] c;
        logic [7:0]  m;
        a = {it.f, it.ir, it.s};
        w = rom(a);
        c = it.iss ? w[14:1] : 14'h0;
        m = (it.iss && !w[0]) ? {5'b0, it.ir[5:3]} : 8'h0;
        return {a, c, m, it.s, it.s == 3'd1, it.s != 3'd0, it.h};
    endfunction

    function automatic void push(
        input logic [2:0] s, input logic [7:0] ir,
        input logic iss = 1'b1, input logic h = 1'b0,
        input logic [7:0] d = 8'h00, input logic c = 1'b0,
        input logic r = 1'b1, input logic st = 1'b0,
        input logic [1:0] f = 2'b00);
        item_t it;
        it.s = s; it.ir = ir; it.iss = iss; it.h = h;
        it.d = d; it.c = c; it.r = r; it.st = st; it.f = f;
        q.push_back(it);
    endfunction

    task automatic apply(input item_t it);
        nrst  = it.r;
        din   = it.d;
        cont  = it.c;
        stall = it.st;
        flags = it.f;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        nrst = 1'b0; din = 8'h00; cont = 1'b0; stall = 1'b0; flags = 2'b00;
    endtask

    task automatic test_reset();
        item_t it;
        logic [OBS_W-1:0] e;
        int n;
        force_ones = 1'b1;
        push(3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        push(3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        push(3'd0, 8'h00);
        push(3'd1, 8'h00);
        push(3'd2, 8'h00);
        push(3'd0, 8'h00);
        n = 0;
        while (q.size() > 0) begin
            it = q.pop_front();
            @(posedge clk); #1;
            apply(it);
            @(negedge clk);
            e = expv(it);
            total_cnt++;
            if (obs() !== e)
                $display("FAIL reset[%0d]: got %h want %h", n, obs(), e);
            else pass_cnt++;
            n++;
        end
        force_ones = 1'b0;
    endtask

    task automatic test_fetch();
        item_t it;
        logic [OBS_W-1:0] e;
        int n;
        nimm = 1'b0; uend_mask = 8'h04;
        do_reset();
        push(3'd0, 8'h00);
        push(3'd1, 8'h00, 1'b1, 1'b0, 8'h2B);
        push(3'd2, 8'h2B);
        push(3'd0, 8'h2B);
        push(3'd1, 8'h2B, 1'b1, 1'b0, 8'h11);
        push(3'd2, 8'h11);
        push(3'd0, 8'h11);
        n = 0;
        while (q.size() > 0) begin
            it = q.pop_front();
            @(posedge clk); #1;
            apply(it);
            @(negedge clk);
            e = expv(it);
            total_cnt++;
            if (obs() !== e)
                $display("FAIL fetch[%0d]: got %h want %h", n, obs(), e);
            else pass_cnt++;
            n++;
        end
    endtask

    task automatic test_var_len();
        item_t it;
        logic [OBS_W-1:0] e;
        int n;
        nimm = 1'b1; uend_mask = 8'h8B;
        do_reset();
        push(3'd0, 8'h00);
        push(3'd1, 8'h00);
        push(3'd2, 8'h00);
        push(3'd3, 8'h00);
        push(3'd0, 8'h00);
        push(3'd1, 8'h00);
        n = 0;
        while (q.size() > 0) begin
            it = q.pop_front();
            @(posedge clk); #1;
            apply(it);
            @(negedge clk);
            e = expv(it);
            total_cnt++;
            if (obs() !== e)
                $display("FAIL var_len[%0d]: got %h want %h", n, obs(), e);
            else pass_cnt++;
            n++;
        end
        // uEnd only at steps 0, 1 and 7: full-length program that wraps
        uend_mask = 8'h83;
        do_reset();
        for (int k = 0; k < 8; k++) push(3'(k), 8'h00);
        push(3'd0, 8'h00);
        push(3'd1, 8'h00);
        n = 0;
        while (q.size() > 0) begin
            it = q.pop_front();
            @(posedge clk); #1;
            apply(it);
            @(negedge clk);
            e = expv(it);
            total_cnt++;
            if (obs() !== e)
                $display("FAIL wrap[%0d]: got %h want %h", n, obs(), e);
            else pass_cnt++;
            n++;
        end
    endtask

    task automatic test_halt();
        item_t it;
        logic [OBS_W-1:0] e;
        int n;
        nimm = 1'b0; uend_mask = 8'h04;
        do_reset();
        push(3'd0, 8'h00);
        push(3'd1, 8'h00, 1'b1, 1'b0, 8'hFF);
        push(3'd2, 8'hFF, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) push(3'd2, 8'hFF, 1'b0, 1'b1);
        push(3'd2, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b1);
        push(3'd0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        push(3'd1, 8'h00, 1'b1, 1'b0, 8'h2B);
        push(3'd2, 8'h2B);
        push(3'd0, 8'h2B);
        n = 0;
        while (q.size() > 0) begin
            it = q.pop_front();
            @(posedge clk); #1;
            apply(it);
            @(negedge clk);
            e = expv(it);
            total_cnt++;
            if (obs() !== e)
                $display("FAIL halt[%0d]: got %h want %h", n, obs(), e);
            else pass_cnt++;
            n++;
        end
    endtask

    task automatic test_reset_priority();
        item_t it;
        logic [OBS_W-1:0] e;
        int n;
        nimm = 1'b0; uend_mask = 8'h10;
        do_reset();
        push(3'd0, 8'h00);
        push(3'd1, 8'h00, 1'b1, 1'b0, 8'hFF);
        push(3'd2, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        push(3'd0, 8'h00);
        push(3'd1, 8'h00, 1'b1, 1'b0, 8'h5A);
        push(3'd2, 8'h5A);
        push(3'd3, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        push(3'd0, 8'h00);
        n = 0;
        while (q.size() > 0) begin
            it = q.pop_front();
            @(posedge clk); #1;
            apply(it);
            @(negedge clk);
            e = expv(it);
            total_cnt++;
            if (obs() !== e)
                $display("FAIL rst_prio[%0d]: got %h want %h", n, obs(), e);
            else pass_cnt++;
            n++;
        end
    endtask

    task automatic test_flags();
        item_t it;
        logic [OBS_W-1:0] e;
        int n;
        nimm = 1'b0; uend_mask = 8'h08;
        do_reset();
        push(3'd0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'b01);
        push(3'd1, 8'h00, 1'b1, 1'b0, 8'h2B, 1'b0, 1'b1, 1'b0, 2'b11);
        push(3'd2, 8'h2B, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'b10);
        push(3'd3, 8'h2B, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'b01);
        push(3'd0, 8'h2B, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'b10);
        n = 0;
        while (q.size() > 0) begin
            it = q.pop_front();
            @(posedge clk); #1;
            apply(it);
            @(negedge clk);
            e = expv(it);
            total_cnt++;
            if (obs() !== e)
                $display("FAIL flags[%0d]: got %h want %h", n, obs(), e);
            else pass_cnt++;
            n++;
        end
    endtask

`ifdef MICROSEQ_STALL_EN
    task automatic test_stall();
        item_t it;
        logic [OBS_W-1:0] e;
        int n;
        nimm = 1'b0; uend_mask = 8'h04;
        do_reset();
        push(3'd0, 8'h00);
        push(3'd1, 8'h00, 1'b1, 1'b0, 8'h2B);
        for (int k = 0; k < 3; k++)
            push(3'd2, 8'h2B, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        push(3'd2, 8'h2B);
        push(3'd0, 8'h2B);
        push(3'd1, 8'h2B, 1'b1, 1'b0, 8'h33);
        push(3'd2, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        push(3'd0, 8'h00);
        push(3'd1, 8'h00, 1'b1, 1'b0, 8'hFF);
        push(3'd2, 8'hFF, 1'b0, 1'b0);
        push(3'd2, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
        push(3'd0, 8'h00);
        n = 0;
        while (q.size() > 0) begin
            it = q.pop_front();
            @(posedge clk); #1;
            apply(it);
            @(negedge clk);
            e = expv(it);
            total_cnt++;
            if (obs() !== e)
                $display("FAIL stall[%0d]: got %h want %h", n, obs(), e);
            else pass_cnt++;
            n++;
        end
    endtask
`endif

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        nrst       = 1'b0;
        din        = 8'h00;
        cont       = 1'b0;
        stall      = 1'b0;
        flags      = 2'b00;
        force_ones = 1'b1;
        nimm       = 1'b1;
        uend_mask  = 8'h04;
        test_reset();
        test_fetch();
        test_var_len();
        test_halt();
        test_reset_priority();
        test_flags();
`ifdef MICROSEQ_STALL_EN
        test_stall();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
